// File: rtl/regfile_port_arbiter_if.sv
// regfile_port_arbiter_if
// Client-side bus of the register-file port arbiter. Lane 0 is the execute
// stage and lane 1 is the load/debug unit. Lane i of a packed field sits at
// [i*W +: W].
//   c_valid/c_write   request valid and op per lane (1 = write)
//   c_s/c_t/c_d       read addr A, read addr B, write addr per lane
//   c_data            write data per lane
//   c_ready           one-hot accept strobe, combinational in the grant cycle
//   rsp_valid         one-hot completion strobe, no backpressure
//   rsp_write         completion was a write
//   rsp_a/rsp_b       read data (0 for writes)
// Modports: master = client side, slave = arbiter side.
interface regfile_port_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [1:0]          c_valid;
  logic [1:0]          c_write;
  logic [2*ADDR_W-1:0] c_s;
  logic [2*ADDR_W-1:0] c_t;
  logic [2*ADDR_W-1:0] c_d;
  logic [2*DATA_W-1:0] c_data;
  logic [1:0]          c_ready;
  logic [1:0]          rsp_valid;
  logic                rsp_write;
  logic [DATA_W-1:0]   rsp_a;
  logic [DATA_W-1:0]   rsp_b;

  modport master (
    output c_valid, c_write, c_s, c_t, c_d, c_data,
    input  c_ready, rsp_valid, rsp_write, rsp_a, rsp_b
  );

  modport slave (
    input  c_valid, c_write, c_s, c_t, c_d, c_data,
    output c_ready, rsp_valid, rsp_write, rsp_a, rsp_b
  );
endinterface

// File: rtl/regfile_port_arbiter.sv
// regfile_port_arbiter
// Shares the single read-or-write port of the 16 x 32b register file between
// two clients with round-robin arbitration. Each access is one READ phase
// (followed by a CAPTURE of the file's registered outputs) or one WRITE phase.
// Ports:
//   clock              rising-edge clock
//   reset              asynchronous, active-low
//   cBus               client bus (slave modport of regfile_port_arbiter_if)
//   rf_wp              to file: 1 = read/protect, 0 = write this edge
//   rf_s/rf_t/rf_d     file read addr A, read addr B, write addr
//   rf_din             file write data
//   rf_outA/rf_outB    file read data, registered inside the file
// Build option:
//   RF_ARB_ZERO_GUARD_EN  when defined, writes to register 0 are suppressed
//                         (still acknowledged); reads of r0 are unaffected.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for a request; grants combinationally, latches fields
// READ    | rf_s/rf_t presented, file registers its outputs at end edge
// CAPTURE | file outputs copied to rsp_a/rsp_b, rsp_valid next cycle
// WRITE   | rf_wp low (unless suppressed), rsp_valid next cycle
module regfile_port_arbiter #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  regfile_port_arbiter_if.slave cBus,
  output logic                  rf_wp,
  output logic [ADDR_W-1:0]     rf_s,
  output logic [ADDR_W-1:0]     rf_t,
  output logic [ADDR_W-1:0]     rf_d,
  output logic [DATA_W-1:0]     rf_din,
  input  logic [DATA_W-1:0]     rf_outA,
  input  logic [DATA_W-1:0]     rf_outB
);

`ifdef RF_ARB_ZERO_GUARD_EN
  localparam bit ZeroGuard = 1'b1;
`else
  localparam bit ZeroGuard = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, READ, CAPTURE, WRITE} arbState_t;

  arbState_t         state;
  arbState_t         nextState;
  logic              lastGrant;
  logic              activeIdx;
  logic              grantReq;
  logic              grantIdx;
  logic              selWrite;
  logic [ADDR_W-1:0] selS;
  logic [ADDR_W-1:0] selT;
  logic [ADDR_W-1:0] selD;
  logic [DATA_W-1:0] selData;
  logic              writeAllowed;
  logic [1:0]        activeOneHot;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // On a tie the lane that did not win last time goes first; lastGrant
  // resets to 1 so the first tie after reset goes to lane 0.
  always_comb begin
    nextState = state;
    grantReq  = 1'b0;
    grantIdx  = ~lastGrant;
    case (state)
      IDLE: begin
        if (cBus.c_valid != 2'b00) begin
          grantReq = 1'b1;
          if (cBus.c_valid != 2'b11) begin
            grantIdx = cBus.c_valid[1];
          end
          nextState = selWrite ? WRITE : READ;
        end
      end
      READ:    nextState = CAPTURE;
      CAPTURE: nextState = IDLE;
      WRITE:   nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  assign selWrite = grantIdx ? cBus.c_write[1] : cBus.c_write[0];
  assign selS     = grantIdx ? cBus.c_s[2*ADDR_W-1:ADDR_W] : cBus.c_s[ADDR_W-1:0];
  assign selT     = grantIdx ? cBus.c_t[2*ADDR_W-1:ADDR_W] : cBus.c_t[ADDR_W-1:0];
  assign selD     = grantIdx ? cBus.c_d[2*ADDR_W-1:ADDR_W] : cBus.c_d[ADDR_W-1:0];
  assign selData  = grantIdx ? cBus.c_data[2*DATA_W-1:DATA_W] : cBus.c_data[DATA_W-1:0];

  // Out-of-range (and, with the guard, r0) writes still run the WRITE phase
  // and get acked, but rf_wp never drops so the file is untouched.
  assign writeAllowed = ({{(32-ADDR_W){1'b0}}, selD} < 32'(NUM_REGS)) &&
                        !(ZeroGuard && (selD == '0));

  // Gated by reset so no handshake can complete while the block is held.
  assign cBus.c_ready = (reset && grantReq) ? (grantIdx ? 2'b10 : 2'b01) : 2'b00;

  assign activeOneHot = activeIdx ? 2'b10 : 2'b01;

  // rf_wp is a register with async preset: asserting reset cancels a write
  // in flight before the next edge can commit it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      lastGrant      <= 1'b1;
      activeIdx      <= 1'b0;
      rf_wp          <= 1'b1;
      rf_s           <= '0;
      rf_t           <= '0;
      rf_d           <= '0;
      rf_din         <= '0;
      cBus.rsp_valid <= 2'b00;
      cBus.rsp_write <= 1'b0;
      cBus.rsp_a     <= '0;
      cBus.rsp_b     <= '0;
    end else begin
      cBus.rsp_valid <= 2'b00;
      case (state)
        IDLE: begin
          if (grantReq) begin
            lastGrant <= grantIdx;
            activeIdx <= grantIdx;
            rf_s      <= selS;
            rf_t      <= selT;
            rf_d      <= selD;
            rf_din    <= selData;
            rf_wp     <= ~(selWrite && writeAllowed);
          end
        end
        CAPTURE: begin
          cBus.rsp_valid <= activeOneHot;
          cBus.rsp_write <= 1'b0;
          cBus.rsp_a     <= rf_outA;
          cBus.rsp_b     <= rf_outB;
        end
        WRITE: begin
          rf_wp          <= 1'b1;
          cBus.rsp_valid <= activeOneHot;
          cBus.rsp_write <= 1'b1;
          cBus.rsp_a     <= '0;
          cBus.rsp_b     <= '0;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// tb_regfile_port_arbiter
// Bench for regfile_port_arbiter: a behavioural register file sits on the rf_*
// side; a transaction-level reference model (expected memory contents,
// round-robin choice, fixed access latencies) predicts every handshake,
// completion and file-port cycle.
module tb_regfile_port_arbiter;
  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 16;

`ifdef RF_ARB_ZERO_GUARD_EN
  localparam bit ZERO_GUARD = 1'b1;
`else
  localparam bit ZERO_GUARD = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  regfile_port_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  logic              rf_wp;
  logic [ADDR_W-1:0] rf_s, rf_t, rf_d;
  logic [DATA_W-1:0] rf_din, rf_outA, rf_outB;

  regfile_port_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS)) dut (
    .clock   (clock),
    .reset   (reset),
    .cBus    (bus),
    .rf_wp   (rf_wp),
    .rf_s    (rf_s),
    .rf_t    (rf_t),
    .rf_d    (rf_d),
    .rf_din  (rf_din),
    .rf_outA (rf_outA),
    .rf_outB (rf_outB)
  );

  // Register file: writes every edge with rf_wp low, registered read outputs,
  // 0 for out-of-range addresses.
  logic [DATA_W-1:0] fileMem [NUM_REGS];
  bit fileInit;
  always @(posedge clock) begin
    if (!fileInit) begin
      for (int i = 0; i < NUM_REGS; i++) fileMem[i] <= 32'(i) * 32'h1111_1111;
      fileInit <= 1'b1;
    end else if (!rf_wp && int'(rf_d) < NUM_REGS) begin
      fileMem[rf_d[3:0]] <= rf_din;
    end
    rf_outA <= (int'(rf_s) < NUM_REGS) ? fileMem[rf_s[3:0]] : 32'h0;
    rf_outB <= (int'(rf_t) < NUM_REGS) ? fileMem[rf_t[3:0]] : 32'h0;
  end

  int testsRun = 0;
  int testsFailed = 0;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // reference model state
  logic [31:0] refMem [NUM_REGS];
  int cyc, freeAt, rspAt, wpAt, opAt, rspIdx, dropIdx;
  bit lastG, dropPending, autoGen, tieMode, rspWr, opWr, opAllowed;
  logic [4:0]  opS, opT, opD;
  logic [31:0] opData, expA, expB, lastRspA, lastRspB;
  logic [1:0]  seenReady;
  int tieCnt0, tieCnt1;

  // client request lanes (driven) and staged directed requests
  logic        reqValid [2], reqWrite [2], stValid [2], stWrite [2];
  logic [4:0]  reqS [2], reqT [2], reqD [2], stS [2], stT [2], stD [2];
  logic [31:0] reqData [2], stData [2];

  function automatic logic [31:0] readModel(input logic [4:0] a);
    return (int'(a) < NUM_REGS) ? refMem[a[3:0]] : 32'h0;
  endfunction

  function automatic bit writeModelAllowed(input logic [4:0] d);
    return (int'(d) < NUM_REGS) && !(ZERO_GUARD && d == 5'd0);
  endfunction

  function automatic logic [1:0] oneHot(input int i);
    return (i == 1) ? 2'b10 : 2'b01;
  endfunction

  task automatic driveBus();
    bus.c_valid = {reqValid[1], reqValid[0]};
    bus.c_write = {reqWrite[1], reqWrite[0]};
    bus.c_s     = {reqS[1], reqS[0]};
    bus.c_t     = {reqT[1], reqT[0]};
    bus.c_d     = {reqD[1], reqD[0]};
    bus.c_data  = {reqData[1], reqData[0]};
  endtask

  task automatic resetModel();
    rspAt = -1; wpAt = -1; opAt = -1; freeAt = 0;
    lastG = 1'b1; dropPending = 1'b0;
    for (int i = 0; i < 2; i++) begin
      reqValid[i] = 1'b0; reqWrite[i] = 1'b0; reqS[i] = '0; reqT[i] = '0;
      reqD[i] = '0; reqData[i] = '0; stValid[i] = 1'b0;
    end
  endtask

  task automatic stageReq(input int i, input bit wr, input logic [4:0] s, input logic [4:0] t,
                          input logic [4:0] d, input logic [31:0] data);
    stValid[i] = 1'b1; stWrite[i] = wr; stS[i] = s; stT[i] = t; stD[i] = d; stData[i] = data;
  endtask

  task automatic randomReq(input int i);
    reqValid[i] = 1'b1;
    reqWrite[i] = 1'($urandom_range(0, 1));
    reqS[i]     = 5'($urandom_range(0, 19));
    reqT[i]     = 5'($urandom_range(0, 19));
    reqD[i]     = 5'($urandom_range(0, 19));
    reqData[i]  = $urandom();
  endtask

  // One clock cycle: drop the request granted last edge, check registered
  // outputs against the model, present new requests, check c_ready.
  task automatic stepCycle();
    int g;
    logic [1:0] expReady;
    @(posedge clock);
    cyc++;
    #1;
    if (dropPending) begin
      reqValid[dropIdx] = 1'b0;
      dropPending = 1'b0;
      driveBus();
    end
    @(negedge clock);
    if (cyc == rspAt) begin
      checkVal("rspValid", bus.rsp_valid, oneHot(rspIdx));
      checkVal("rspWrite", bus.rsp_write, rspWr);
      checkVal("rspA", bus.rsp_a, expA);
      checkVal("rspB", bus.rsp_b, expB);
      lastRspA = bus.rsp_a;
      lastRspB = bus.rsp_b;
      if (rspWr && opAllowed) refMem[opD[3:0]] = opData;
      rspAt = -1;
    end else begin
      checkVal("rspIdle", bus.rsp_valid, 2'b00);
    end
    checkVal("rfWp", rf_wp, (cyc == wpAt) ? 1'b0 : 1'b1);
    if (cyc == opAt) begin
      if (opWr) begin
        checkVal("rfD", rf_d, opD);
        checkVal("rfDin", rf_din, opData);
      end else begin
        checkVal("rfS", rf_s, opS);
        checkVal("rfT", rf_t, opT);
      end
    end
    for (int i = 0; i < 2; i++) begin
      if (!reqValid[i]) begin
        if (stValid[i]) begin
          reqValid[i] = 1'b1; reqWrite[i] = stWrite[i]; reqS[i] = stS[i];
          reqT[i] = stT[i]; reqD[i] = stD[i]; reqData[i] = stData[i];
          stValid[i] = 1'b0;
        end else if (autoGen && (tieMode || $urandom_range(0, 3) != 0)) begin
          randomReq(i);
        end
      end
    end
    driveBus();
    #1;
    expReady = 2'b00;
    if (cyc >= freeAt && (reqValid[0] || reqValid[1])) begin
      g = (reqValid[0] && reqValid[1]) ? (lastG ? 0 : 1) : (reqValid[1] ? 1 : 0);
      expReady = oneHot(g);
      lastG = (g == 1);
      dropIdx = g; dropPending = 1'b1;
      rspIdx = g; opAt = cyc + 1;
      opWr = reqWrite[g]; opS = reqS[g]; opT = reqT[g]; opD = reqD[g]; opData = reqData[g];
      if (opWr) begin
        opAllowed = writeModelAllowed(opD);
        wpAt = opAllowed ? cyc + 1 : -1;
        rspAt = cyc + 2; freeAt = cyc + 2;
        expA = 32'h0; expB = 32'h0; rspWr = 1'b1;
      end else begin
        opAllowed = 1'b0; wpAt = -1;
        rspAt = cyc + 3; freeAt = cyc + 3;
        expA = readModel(opS); expB = readModel(opT); rspWr = 1'b0;
      end
    end
    seenReady = bus.c_ready;
    if (tieMode && seenReady == 2'b01) tieCnt0++;
    if (tieMode && seenReady == 2'b10) tieCnt1++;
    checkVal("cReady", seenReady, expReady);
  endtask

  task automatic runUntilQuiet();
    int n;
    n = 0;
    do begin
      stepCycle();
      n++;
    end while ((reqValid[0] || reqValid[1] || stValid[0] || stValid[1] || rspAt >= 0) && n < 60);
    checkVal("quietBound", (n < 60), 1'b1);
  endtask

  task automatic dumpCheck();
    for (int i = 0; i < NUM_REGS; i++) checkVal($sformatf("dump%0d", i), fileMem[i], refMem[i]);
  endtask

  task automatic checkResetOutputs();
    checkVal("rstReady", bus.c_ready, 2'b00);
    checkVal("rstRspValid", bus.rsp_valid, 2'b00);
    checkVal("rstRspWrite", bus.rsp_write, 1'b0);
    checkVal("rstRspA", bus.rsp_a, 32'h0);
    checkVal("rstRspB", bus.rsp_b, 32'h0);
    checkVal("rstWp", rf_wp, 1'b1);
    checkVal("rstS", rf_s, 5'd0);
    checkVal("rstT", rf_t, 5'd0);
    checkVal("rstD", rf_d, 5'd0);
    checkVal("rstDin", rf_din, 32'h0);
  endtask

  initial begin
    for (int i = 0; i < NUM_REGS; i++) refMem[i] = 32'(i) * 32'h1111_1111;
    resetModel();
    autoGen = 1'b0; tieMode = 1'b0; cyc = 0; tieCnt0 = 0; tieCnt1 = 0;
    lastRspA = '0; lastRspB = '0;
    reset = 1'b0;
    driveBus();
    bus.c_valid = 2'b11;
    repeat (3) @(posedge clock);
    @(negedge clock);
    checkResetOutputs();
    driveBus();
    reset = 1'b1;

    // client 0 write r3, then client 1 reads r3 and r0
    stageReq(0, 1'b1, 5'd0, 5'd0, 5'd3, 32'hDEAD_BEEF);
    runUntilQuiet();
    stageReq(1, 1'b0, 5'd3, 5'd0, 5'd0, 32'h0);
    runUntilQuiet();
    checkVal("dirRdA", lastRspA, 32'hDEAD_BEEF);
    checkVal("dirRdB", lastRspB, 32'h0);

    // idle: rf_wp held high, file untouched
    repeat (20) stepCycle();
    dumpCheck();

    // out-of-range write
    stageReq(0, 1'b1, 5'd0, 5'd0, 5'd20, 32'h5555_AAAA);
    runUntilQuiet();
    dumpCheck();

    // write to r0 then read it back
    stageReq(1, 1'b1, 5'd0, 5'd0, 5'd0, 32'h1234_5678);
    runUntilQuiet();
    stageReq(0, 1'b0, 5'd0, 5'd3, 5'd0, 32'h0);
    runUntilQuiet();
    checkVal("zeroRdA", lastRspA, ZERO_GUARD ? 32'h0 : 32'h1234_5678);
    checkVal("zeroRdB", lastRspB, 32'hDEAD_BEEF);

    // random traffic, then saturated ties
    autoGen = 1'b1;
    repeat (500) stepCycle();
    tieMode = 1'b1;
    repeat (40) stepCycle();
    tieMode = 1'b0;
    autoGen = 1'b0;
    runUntilQuiet();
    checkVal("tieBalance", ((tieCnt0 - tieCnt1) <= 1 && (tieCnt1 - tieCnt0) <= 1), 1'b1);
    dumpCheck();

    // reset asserted in the middle of a write
    stageReq(1, 1'b1, 5'd0, 5'd0, 5'd5, 32'hCAFE_F00D);
    stepCycle();
    checkVal("mwGrant", seenReady, 2'b10);
    stepCycle();
    reset = 1'b0;
    #1;
    checkVal("mwWp", rf_wp, 1'b1);
    checkVal("mwRsp", bus.rsp_valid, 2'b00);
    resetModel();
    driveBus();
    repeat (2) @(posedge clock);
    @(negedge clock);
    checkVal("mwRspHeld", bus.rsp_valid, 2'b00);
    checkVal("mwFile", fileMem[5], refMem[5]);
    reset = 1'b1;
    stageReq(0, 1'b0, 5'd5, 5'd3, 5'd0, 32'h0);
    stageReq(1, 1'b0, 5'd1, 5'd2, 5'd0, 32'h0);
    stepCycle();
    checkVal("postRstGrant", seenReady, 2'b01);
    runUntilQuiet();
    dumpCheck();

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
